alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the ALU arbiter and its environment.
// slave is the arbiter's view; master is the view of the clients, ALU and response consumer.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned OPCODE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 15
);
  localparam int unsigned OW    = OPCODE_WIDTH + 1;
  localparam int unsigned DW    = DATA_WIDTH + 1;
  localparam int unsigned CNT_W = 16;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*OW-1:0] req_opcode;
  logic [NUM_REQ*DW-1:0] req_op1;
  logic [NUM_REQ*DW-1:0] req_op2;

  logic [OW-1:0]         alu_opcode;
  logic [DW-1:0]         alu_op1;
  logic [DW-1:0]         alu_op2;
  logic [DW-1:0]         alu_result;
  logic                  alu_carry;
  logic                  alu_zero;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_WIDTH-1:0]   resp_id;
  logic [DW-1:0]         resp_data;
  logic                  resp_carry;
  logic                  resp_zero;
  logic [CNT_W-1:0]      grant_count;

  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2,
    input  alu_result, alu_carry, alu_zero,
    input  resp_ready,
    output req_ready,
    output alu_opcode, alu_op1, alu_op2,
    output resp_valid, resp_id, resp_data, resp_carry, resp_zero, grant_count
  );

  modport master (
    output req_valid, req_opcode, req_op1, req_op2,
    output alu_result, alu_carry, alu_zero,
    output resp_ready,
    input  req_ready,
    input  alu_opcode, alu_op1, alu_op2,
    input  resp_valid, resp_id, resp_data, resp_carry, resp_zero, grant_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NUM_REQ requesters; each grant
// issues operands, captures the ALU result two cycles later and returns it tagged by ID.
module alu_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_WIDTH     = 2,
  parameter int unsigned OPCODE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 15
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam int unsigned OW    = OPCODE_WIDTH + 1;
  localparam int unsigned DW    = DATA_WIDTH + 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SLOTS = 1 << ID_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] owner;
  logic [OW-1:0]       opcode_q;
  logic [DW-1:0]       op1_q;
  logic [DW-1:0]       op2_q;
  logic                resp_valid_q;
  logic [ID_WIDTH-1:0] resp_id_q;
  logic [DW-1:0]       resp_data_q;
  logic                resp_carry_q;
  logic                resp_zero_q;
  logic [CNT_W-1:0]    grant_count_q;

  logic [SLOTS-1:0]    valid_ext;
  logic [SLOTS*OW-1:0] opc_flat;
  logic [SLOTS*DW-1:0] op1_flat;
  logic [SLOTS*DW-1:0] op2_flat;
  logic [OW-1:0]       opc_arr [SLOTS];
  logic [DW-1:0]       op1_arr [SLOTS];
  logic [DW-1:0]       op2_arr [SLOTS];

  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_hit;
  logic                take;
  int unsigned         cand;

  // Pad to a power-of-two table so the grant index selects without range checks
  assign valid_ext = SLOTS'(bus.req_valid);
  assign opc_flat  = (SLOTS*OW)'(bus.req_opcode);
  assign op1_flat  = (SLOTS*DW)'(bus.req_op1);
  assign op2_flat  = (SLOTS*DW)'(bus.req_op2);

  for (genvar g = 0; g < SLOTS; g++) begin : g_unpack
    assign opc_arr[g] = opc_flat[g*OW +: OW];
    assign op1_arr[g] = op1_flat[g*DW +: DW];
    assign op2_arr[g] = op2_flat[g*DW +: DW];
  end

  // First valid requester after last_grant, wrapping at NUM_REQ (not at 2^ID_WIDTH)
  always_comb begin
    cand      = 0;
    grant_idx = '0;
    grant_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(last_grant) + k + 32'd1;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_hit && valid_ext[ID_WIDTH'(cand)]) begin
        grant_hit = 1'b1;
        grant_idx = ID_WIDTH'(cand);
      end
    end
  end

  assign take          = (state == IDLE) && !rst && grant_hit;
  assign bus.req_ready = take ? NUM_REQ'(SLOTS'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= ID_WIDTH'(NUM_REQ - 1);
      owner         <= '0;
      opcode_q      <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      resp_carry_q  <= 1'b0;
      resp_zero_q   <= 1'b0;
      grant_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            opcode_q      <= opc_arr[grant_idx];
            op1_q         <= op1_arr[grant_idx];
            op2_q         <= op2_arr[grant_idx];
            owner         <= grant_idx;
            last_grant    <= grant_idx;
            grant_count_q <= grant_count_q + CNT_W'(1);
            state         <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          // ALU registered the issued operands at the end of ISSUE
          resp_data_q  <= bus.alu_result;
          resp_carry_q <= bus.alu_carry;
          resp_zero_q  <= bus.alu_zero;
          resp_id_q    <= owner;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_carry  = resp_carry_q;
  assign bus.resp_zero   = resp_zero_q;
  assign bus.grant_count = grant_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (round-robin pick, fixed latency, ALU function).
module tb_alu_arbiter;
  localparam int unsigned NR = 4;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd4, OP_DEC = 3'd6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(4), .ID_WIDTH(2), .OPCODE_WIDTH(2), .DATA_WIDTH(15)) bus ();

  alu_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .OPCODE_WIDTH(2), .DATA_WIDTH(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference ALU function: {carry/borrow, zero, result}
  function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    case (op)
      3'd0:    s = {1'b0, x} + {1'b0, y};
      3'd1:    s = {1'b0, x} - {1'b0, y};
      3'd2:    s = {1'b0, x & y};
      3'd3:    s = {1'b0, x | y};
      3'd4:    s = {1'b0, x ^ y};
      3'd5:    s = {1'b0, x} + 17'd1;
      3'd6:    s = {1'b0, x} - 17'd1;
      default: s = {1'b0, x};
    endcase
    return {s[16], s[15:0] == 16'd0, s[15:0]};
  endfunction

  // Registered ALU seen by the arbiter
  always_ff @(posedge clk)
    {bus.alu_carry, bus.alu_zero, bus.alu_result} <= alu_fn(bus.alu_opcode, bus.alu_op1, bus.alu_op2);

  // Stimulus state
  logic [NR-1:0] valid;
  logic [2:0]    opc [NR];
  logic [15:0]   a [NR];
  logic [15:0]   b [NR];
  logic          rdy, rst_i;
  bit            hold_all;

  // Model state
  int          m_last, m_count, t_since, cur_id, last_pick;
  logic [17:0] cur;
  logic [2:0]  e_op;
  logic [15:0] e_a, e_b, e_data;
  logic        e_c, e_z;
  int          e_id;

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive();
    rst            = rst_i;
    bus.req_valid  = valid;
    bus.resp_ready = rdy;
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_opcode[i*3 +: 3] = opc[i];
      bus.req_op1[i*16 +: 16]  = a[i];
      bus.req_op2[i*16 +: 16]  = b[i];
    end
  endtask

  task automatic model_reset();
    m_last = int'(NR) - 1; m_count = 0; t_since = -1; cur_id = 0; cur = '0;
    e_op = '0; e_a = '0; e_b = '0; e_data = '0; e_c = 1'b0; e_z = 1'b0; e_id = 0;
  endtask

  // Compare all outputs with the model mid-cycle, then advance the model one clock
  task automatic sample();
    int pick;
    logic [NR-1:0] er;
    @(negedge clk);
    pick = -1;
    if (!rst_i && t_since < 0)
      for (int k = 1; k <= int'(NR); k++) begin
        int c;
        c = (m_last + k) % int'(NR);
        if (pick < 0 && valid[c]) pick = c;
      end
    er = '0;
    if (pick >= 0) er[pick] = 1'b1;
    check("req_ready",   32'(bus.req_ready), 32'(er));
    check("resp_valid",  32'(bus.resp_valid), 32'(t_since >= 3));
    check("resp_id",     32'(bus.resp_id), e_id);
    check("resp_data",   32'(bus.resp_data), 32'(e_data));
    check("resp_flags",  {bus.resp_carry, bus.resp_zero}, {e_c, e_z});
    check("grant_count", 32'(bus.grant_count), m_count);
    check("alu_opcode",  32'(bus.alu_opcode), 32'(e_op));
    check("alu_ops",     {bus.alu_op1, bus.alu_op2}, {e_a, e_b});
    last_pick = pick;
    if (rst_i) model_reset();
    else if (pick >= 0) begin
      t_since = 1; m_last = pick; m_count = (m_count + 1) & 32'hFFFF;
      e_op = opc[pick]; e_a = a[pick]; e_b = b[pick];
      cur_id = pick; cur = alu_fn(opc[pick], a[pick], b[pick]);
    end else if (t_since == 3) begin
      if (rdy) t_since = -1;
    end else if (t_since >= 0) begin
      t_since++;
      if (t_since == 3) begin
        e_id = cur_id; {e_c, e_z, e_data} = cur;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (last_pick >= 0) begin
      if (hold_all) begin
        opc[last_pick] = 3'($urandom); a[last_pick] = rand_operand(); b[last_pick] = rand_operand();
      end else valid[last_pick] = 1'b0;
    end
    drive();
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; drive(); cyc(); rst_i = 1'b0; drive();
  endtask

  task automatic drain();
    rdy = 1'b1; drive();
    for (int n = 0; n < 60; n++) begin
      if (valid == '0 && t_since < 0) return;
      cyc();
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Single request from one requester; optional backpressure and extra requesters raised after its grant
  task automatic run_one(input int id, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         input int hold, input logic [NR-1:0] extra,
                         output int gid, output logic [15:0] d, output logic c, output logic z, output int rid);
    int nresp;
    bit done, raise;
    valid[id] = 1'b1; opc[id] = op; a[id] = x; b[id] = y; rdy = (hold == 0); drive();
    gid = -1; nresp = 0; done = 1'b0; d = '0; c = 1'b0; z = 1'b0; rid = -1;
    for (int n = 0; n < 40 && !done; n++) begin
      sample();
      raise = 1'b0;
      if (gid < 0 && last_pick == id) begin gid = id; raise = 1'b1; end
      if (gid >= 0 && bus.resp_valid === 1'b1) begin
        if (nresp == 0) begin
          d = bus.resp_data; c = bus.resp_carry; z = bus.resp_zero; rid = int'(bus.resp_id);
        end else begin
          check("hold_data", 32'(bus.resp_data), 32'(d));
          check("hold_flags", {bus.resp_carry, bus.resp_zero}, {c, z});
        end
        nresp++;
        if (rdy) done = 1'b1;
        else begin
          check("hold_no_grant", 32'(bus.req_ready), 32'd0);
          if (nresp >= hold) rdy = 1'b1;
        end
      end
      advance();
      if (raise && extra != '0) begin
        for (int k = 0; k < int'(NR); k++)
          if (extra[k]) begin
            valid[k] = 1'b1; opc[k] = 3'($urandom); a[k] = rand_operand(); b[k] = rand_operand();
          end
        drive();
      end
    end
    if (!done) check("run_timeout", 32'd0, 32'd1);
    else check("resp_len", nresp, hold + 1);
  endtask

  initial begin
    int gid, rid, np;
    int picks[6], pcyc[6];
    logic [15:0] d;
    logic c, z;

    valid = '0; rdy = 1'b1; rst_i = 1'b1; hold_all = 1'b0; last_pick = -1;
    for (int i = 0; i < int'(NR); i++) begin opc[i] = '0; a[i] = '0; b[i] = '0; end
    drive();
    model_reset();
    @(posedge clk); #1;
    cyc();
    rst_i = 1'b0; drive();

    // ADD 0x8000 + 0x8000 from requester 0, latency T -> T+3
    valid[0] = 1'b1; opc[0] = OP_ADD; a[0] = 16'h8000; b[0] = 16'h8000; drive();
    sample(); check("t1_ready", 32'(bus.req_ready), 32'h1); advance();
    cyc(); cyc();
    sample();
    check("t1_valid", 32'(bus.resp_valid), 32'd1);
    check("t1_id",    32'(bus.resp_id), 32'd0);
    check("t1_data",  32'(bus.resp_data), 32'h0000);
    check("t1_carry", 32'(bus.resp_carry), 32'd1);
    check("t1_zero",  32'(bus.resp_zero), 32'd1);
    check("t1_count", 32'(bus.grant_count), 32'd1);
    advance();

    // All four requesting continuously: 0,1,2,3,0,1 every 4 cycles
    reset_dut();
    hold_all = 1'b1; valid = '1; rdy = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin opc[i] = 3'($urandom); a[i] = rand_operand(); b[i] = rand_operand(); end
    drive();
    np = 0;
    for (int n = 0; n < 24; n++) begin
      sample();
      if (last_pick >= 0 && np < 6) begin picks[np] = last_pick; pcyc[np] = n; np++; end
      advance();
    end
    hold_all = 1'b0; valid = '0; drive();
    check("rr_count", np, 6);
    for (int k = 0; k < 6; k++) begin
      check("rr_order", picks[k], k % 4);
      check("rr_spacing", pcyc[k], 4 * k);
    end

    // Grant 3, then only requester 2 with SUB wraps to 2
    run_one(3, OP_ADD, rand_operand(), rand_operand(), 0, '0, gid, d, c, z, rid);
    check("t3_first", gid, 3);
    run_one(2, OP_SUB, 16'h0005, 16'h0003, 0, '0, gid, d, c, z, rid);
    check("t3_grant", gid, 2);
    check("t3_data", 32'(d), 32'h0002);
    check("t3_flags", {c, z}, 2'b00);
    check("t3_id", rid, 2);

    // XOR with 5 cycles of backpressure while others wait
    run_one(0, OP_XOR, 16'hFFFF, 16'hFFFF, 5, 4'b0110, gid, d, c, z, rid);
    check("t4_data", 32'(d), 32'h0000);
    check("t4_flags", {c, z}, 2'b01);
    drain();

    // Reset while in CAPTURE discards the operation
    valid[2] = 1'b1; opc[2] = OP_ADD; a[2] = 16'h1234; b[2] = 16'h0001; rdy = 1'b1; drive();
    sample(); check("t5_grant", last_pick, 2); advance();
    cyc();
    rst_i = 1'b1; drive(); cyc();
    rst_i = 1'b0; valid[0] = 1'b1; valid[3] = 1'b1;
    opc[0] = 3'($urandom); a[0] = rand_operand(); b[0] = rand_operand();
    opc[3] = 3'($urandom); a[3] = rand_operand(); b[3] = rand_operand();
    drive();
    sample();
    check("t5_valid", 32'(bus.resp_valid), 32'd0);
    check("t5_count", 32'(bus.grant_count), 32'd0);
    check("t5_op1", 32'(bus.alu_op1), 32'd0);
    check("t5_first", last_pick, 0);
    advance();
    drain();

    // DEC 0x0000 by requester 1
    run_one(1, OP_DEC, 16'h0000, rand_operand(), 0, '0, gid, d, c, z, rid);
    check("t6_data", 32'(d), 32'hFFFF);
    check("t6_flags", {c, z}, 2'b10);
    check("t6_id", rid, 1);

    // Random traffic with backpressure and occasional reset
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < int'(NR); i++)
        if (!valid[i] && $urandom_range(0, 2) == 0) begin
          valid[i] = 1'b1; opc[i] = 3'($urandom); a[i] = rand_operand(); b[i] = rand_operand();
        end
      rdy   = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 99) == 0);
      drive();
      cyc();
    end
    rst_i = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
